// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard unit: forwarding, stall/flush control, memory-wait FSM, counters
//
// Parameters:
//   WIDTH    width of the StallCount / FlushCount performance counters
//   TIMEOUT  memory-wait cycles allowed before the block locks into FAULT
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   Rs1D, Rs2D                        decode source registers
//   Rs1E, Rs2E, RdE                   execute source / destination registers
//   RdM, RdW, RegWriteM, RegWriteW    memory / writeback destinations and write enables
//   ResultSrcE, PCSrcE                load in execute, taken branch/jump in execute
//   MemReqM, MemReadyM                data-memory request in memory stage, memory ready
//   StallF/D/E/M, FlushD/E/W          stage-register hold and bubble controls
//   ForwardAE, ForwardBE              operand select: 00 regfile, 01 writeback, 10 memory
//   MemTimeout                        sticky memory-timeout fault flag
//   StallCount, FlushCount            saturating performance counters
module hazard_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [WIDTH-1:0] StallCount,
    output logic [WIDTH-1:0] FlushCount
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    localparam int WCW = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_next;
    logic [WCW-1:0]   wait_cnt;
    logic [WCW-1:0]   wait_cnt_next;
    logic             mem_timeout_q;
    logic [WIDTH-1:0] stall_cnt;
    logic [WIDTH-1:0] flush_cnt;

    logic load_use;
    logic mem_miss;
    logic hold_all;     // freeze F..M and bubble W while memory is outstanding
    logic pipe_ctrl;    // normal branch / load-use handling applies this cycle
    logic count_flush;

    // x0 never matches: flushed execute bubbles carry RegWrite=1 with Rd=0.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       we_m,
        input logic [4:0] rd_w,
        input logic       we_w
    );
        if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        end
    end

    assign load_use = ResultSrcE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_miss = MemReqM && !MemReadyM;

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        hold_all      = 1'b0;
        pipe_ctrl     = 1'b0;
        count_flush   = 1'b0;
        StallF        = 1'b0;
        StallD        = 1'b0;
        StallE        = 1'b0;
        StallM        = 1'b0;
        FlushD        = 1'b0;
        FlushE        = 1'b0;
        FlushW        = 1'b0;

        if (!rst_n) begin
            // Bubble the pipeline while reset is held; no stage is held.
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    count_flush = PCSrcE;
                    if (mem_miss) begin
                        hold_all      = 1'b1;
                        state_next    = MEM_WAIT;
                        wait_cnt_next = WCW'(1);
                    end else begin
                        pipe_ctrl = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (MemReadyM) begin
                        // Exit cycle: the pipeline moves again this same cycle.
                        pipe_ctrl     = 1'b1;
                        count_flush   = PCSrcE;
                        state_next    = RUN;
                        wait_cnt_next = '0;
                    end else begin
                        hold_all      = 1'b1;
                        wait_cnt_next = wait_cnt + 1'b1;
                        if (wait_cnt >= WCW'(TIMEOUT - 1)) begin
                            state_next = FAULT;
                        end
                    end
                end
                FAULT: begin
                    hold_all = 1'b1;
                end
                default: begin
                    state_next = RUN;
                end
            endcase

            if (hold_all) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (pipe_ctrl) begin
                // A taken branch squashes the dependent instruction anyway,
                // so it wins over a simultaneous load-use stall.
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (load_use) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            wait_cnt      <= '0;
            mem_timeout_q <= 1'b0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state_next == FAULT) begin
                mem_timeout_q <= 1'b1;
            end
            if (StallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (count_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    assign MemTimeout = mem_timeout_q;
    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;

endmodule
